// File: rtl/mult_pkg.sv
// Constants shared by the multiplier wrapper and the multiplier result queue.
package mult_pkg;

  localparam int MULT_LATENCY_DEF = 4;
  localparam int MULT_DATA_W      = 32;
  localparam int MULT_TAG_W_DEF   = 5;
  localparam int MULT_DEPTH_DEF   = 4;

endpackage

// File: rtl/mult_resq_fifo.sv
// Result FIFO for the multiplier queue: storage, wrapping pointers and an occupancy counter.
module mult_resq_fifo
  import mult_pkg::*;
#(
  parameter int DEPTH = MULT_DEPTH_DEF,
  parameter int TAG_W = MULT_TAG_W_DEF
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_push,
  input  logic [MULT_DATA_W-1:0] i_push_data,
  input  logic [TAG_W-1:0]       i_push_tag,
  input  logic                   i_pop,
  output logic [MULT_DATA_W-1:0] o_head_data,
  output logic [TAG_W-1:0]       o_head_tag,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [MULT_DATA_W-1:0] r_data [DEPTH];
  logic [TAG_W-1:0]       r_tag  [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_push) begin
      r_data[r_wr_ptr] <= i_push_data;
      r_tag[r_wr_ptr]  <= i_push_tag;
    end
  end

  assign o_head_data = r_data[r_rd_ptr];
  assign o_head_tag  = r_tag[r_rd_ptr];
  assign o_count     = r_count;
  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);

  a_no_overflow:  assert property (@(posedge i_clock) disable iff (!i_reset_n) !(i_push && o_full));
  a_no_underflow: assert property (@(posedge i_clock) disable iff (!i_reset_n) !(i_pop && o_empty));

endmodule

// File: rtl/mult_result_queue.sv
// Credit-based result queue behind a fixed-latency multiplier; tracks in-flight tags and buffers products.
// Optional macro MULT_RESQ_BYPASS_EN presents a product combinationally when the FIFO is empty.
module mult_result_queue
  import mult_pkg::*;
#(
  parameter int MULT_LATENCY = MULT_LATENCY_DEF,
  parameter int DEPTH        = MULT_DEPTH_DEF,
  parameter int TAG_W        = MULT_TAG_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   mult_signal,
  input  logic [TAG_W-1:0]       tag_in,
  input  logic [MULT_DATA_W-1:0] mult_result,
  output logic                   input_RDY,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [MULT_DATA_W-1:0] res_data,
  output logic [TAG_W-1:0]       res_tag,
  output logic                   exception
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [MULT_LATENCY-1:0] r_stg_vld;
  logic [TAG_W-1:0]        r_stg_tag [MULT_LATENCY];
  logic                    r_exception;

  logic                   w_accept;
  logic                   w_drop;
  logic                   w_last_vld;
  logic [TAG_W-1:0]       w_last_tag;
  logic                   w_bypass;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [CW-1:0]          w_fifo_count;
  logic [MULT_DATA_W-1:0] w_head_data;
  logic [TAG_W-1:0]       w_head_tag;
  logic [31:0]            w_inflight;
  logic [31:0]            w_credit_used;

  assign w_accept   = mult_signal & input_RDY;
  assign w_drop     = mult_signal & ~input_RDY;
  assign w_last_vld = r_stg_vld[MULT_LATENCY-1];
  assign w_last_tag = r_stg_tag[MULT_LATENCY-1];

  // The pipeline never stalls, so every stage advances on every edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stg_vld   <= '0;
      r_exception <= 1'b0;
      for (int i = 0; i < MULT_LATENCY; i++) r_stg_tag[i] <= '0;
    end else begin
      r_stg_vld[0] <= w_accept;
      r_stg_tag[0] <= tag_in;
      for (int i = 1; i < MULT_LATENCY; i++) begin
        r_stg_vld[i] <= r_stg_vld[i-1];
        r_stg_tag[i] <= r_stg_tag[i-1];
      end
      if (w_drop) r_exception <= 1'b1;
    end
  end

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < MULT_LATENCY; i++) w_inflight = w_inflight + 32'(r_stg_vld[i]);
  end

  // Every in-flight op owns a FIFO slot, so an accepted op can always be pushed.
  assign w_credit_used = w_inflight + 32'(w_fifo_count);
  assign input_RDY     = ~w_fifo_full & (w_credit_used < 32'(DEPTH));

`ifdef MULT_RESQ_BYPASS_EN
  assign w_bypass = w_fifo_empty & w_last_vld;
`else
  assign w_bypass = 1'b0;
`endif

  assign res_valid = ~w_fifo_empty | w_bypass;
  assign w_pop     = ~w_fifo_empty & res_ready;
  assign w_push    = w_last_vld & ~(w_bypass & res_ready);

  always_comb begin
    res_data = '0;
    res_tag  = '0;
    if (w_bypass) begin
      res_data = mult_result;
      res_tag  = w_last_tag;
    end else if (!w_fifo_empty) begin
      res_data = w_head_data;
      res_tag  = w_head_tag;
    end
  end

  assign exception = r_exception;

  mult_resq_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_fifo (
    .i_clock     (clock),
    .i_reset_n   (reset_n),
    .i_push      (w_push),
    .i_push_data (mult_result),
    .i_push_tag  (w_last_tag),
    .i_pop       (w_pop),
    .o_head_data (w_head_data),
    .o_head_tag  (w_head_tag),
    .o_count     (w_fifo_count),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

endmodule

// File: tb/tb_mult_result_queue.sv
// Bench for mult_result_queue: queue-based reference model plus directed scenarios with literal expectations.
module tb_mult_result_queue;

  localparam int L     = 4;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam int EW    = 32 + TAG_W;
`ifdef MULT_RESQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LAT = BYP ? L - 1 : L;

  logic             clock       = 1'b0;
  logic             reset_n     = 1'b1;
  logic             mult_signal = 1'b0;
  logic [TAG_W-1:0] tag_in      = '0;
  logic [31:0]      mult_result = '0;
  logic             res_ready   = 1'b0;
  logic             input_RDY;
  logic             res_valid;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             exception;

  int checks = 0;
  int errors = 0;

  mult_result_queue #(
    .MULT_LATENCY (L),
    .DEPTH        (DEPTH),
    .TAG_W        (TAG_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .mult_signal (mult_signal),
    .tag_in      (tag_in),
    .mult_result (mult_result),
    .input_RDY   (input_RDY),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_tag     (res_tag),
    .exception   (exception)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: pending ops with due edge, FIFO contents as a queue
  typedef struct {
    int               due;
    logic [TAG_W-1:0] tag;
  } pend_t;

  pend_t       pend_q[$];
  logic [EW-1:0] exp_q[$];
  bit          exp_exc = 1'b0;
  int          cyc = 0;

  function automatic bit model_bypass();
    return BYP && exp_q.size() == 0 && pend_q.size() > 0 && pend_q[0].due == cyc;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_q.delete();
      exp_q.delete();
      exp_exc = 1'b0;
    end else begin
      bit    rdy, last, byp, vld;
      pend_t p;
      rdy  = (exp_q.size() + pend_q.size()) < DEPTH;
      last = pend_q.size() > 0 && pend_q[0].due == cyc;
      byp  = model_bypass();
      vld  = exp_q.size() > 0 || byp;
      if (vld && res_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (last) begin
        p = pend_q.pop_front();
        if (!(byp && res_ready)) exp_q.push_back({mult_result, p.tag});
      end
      if (mult_signal) begin
        if (rdy) begin
          p.due = cyc + L;
          p.tag = tag_in;
          pend_q.push_back(p);
        end else begin
          exp_exc = 1'b1;
        end
      end
      cyc++;
    end
  end

  // scoreboard compare on every falling edge
  always @(negedge clock) begin
    bit byp, vld;
    byp = model_bypass();
    vld = exp_q.size() > 0 || byp;
    chk("res_valid", res_valid, vld);
    chk("input_RDY", input_RDY, (exp_q.size() + pend_q.size()) < DEPTH);
    chk("exception", exception, exp_exc);
    if (vld) begin
      chk("res_data", res_data, byp ? mult_result : exp_q[0][EW-1:TAG_W]);
      chk("res_tag", res_tag, byp ? pend_q[0].tag : exp_q[0][TAG_W-1:0]);
    end else if (!reset_n) begin
      chk("reset_res_data", res_data, 0);
      chk("reset_res_tag", res_tag, 0);
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  logic [TAG_W-1:0] got[$];

  task automatic collect(input int max_cycles, input int want);
    for (int c = 0; c < max_cycles && got.size() < want; c++) begin
      mult_result = $urandom;
      if (res_valid && res_ready) got.push_back(res_tag);
      tick();
    end
  endtask

  // driver
  initial begin
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_input_RDY", input_RDY, 1);
    chk("rst_exception", exception, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_tag", res_tag, 0);
    reset_n = 1'b1;

    // single op, tag 3, product 0x0F00
    mult_result = 32'h0000_0F00;
    res_ready   = 1'b1;
    mult_signal = 1'b1;
    tag_in      = 5'd3;
    tick();
    mult_signal = 1'b0;
    tag_in      = '0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t1_res_valid", res_valid, k == LAT);
      if (k == LAT) begin
        chk("t1_res_data", res_data, 32'h0000_0F00);
        chk("t1_res_tag", res_tag, 3);
      end
    end

    // back-to-back issue with consumer stalled
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mult_result = 32'h1000 + 32'(i);
      tag_in      = TAG_W'(i);
      mult_signal = 1'b1;
      chk("t2_input_RDY", input_RDY, i < 4);
      tick();
    end
    mult_signal = 1'b0;
    chk("t2_exception", exception, 1);
    repeat (6) begin
      mult_result = $urandom;
      tick();
    end
    res_ready = 1'b1;
    got.delete();
    collect(20, 4);
    res_ready = 1'b0;
    chk("t2_pop_count", got.size(), 4);
    for (int j = 0; j < got.size(); j++) chk("t2_tag_order", got[j], j);
    chk("t2_exception_sticky", exception, 1);
    do_reset();

    // full FIFO with simultaneous pop and push
    for (int i = 0; i < 4; i++) begin
      tag_in      = TAG_W'(8 + i);
      mult_signal = 1'b1;
      mult_result = $urandom;
      tick();
    end
    mult_signal = 1'b0;
    repeat (3) begin
      mult_result = $urandom;
      tick();
    end
    res_ready = 1'b1;
    chk("t3_rdy_before", input_RDY, 0);
    chk("t3_head_tag", res_tag, 8);
    tick();
    res_ready = 1'b0;
    chk("t3_rdy_after", input_RDY, 1);
    chk("t3_valid_after", res_valid, 1);
    res_ready = 1'b1;
    got.delete();
    collect(12, 4);
    res_ready = 1'b0;
    chk("t3_remaining", got.size(), 3);
    for (int j = 0; j < got.size(); j++) chk("t3_tag_order", got[j], 9 + j);

    // 20 ops with random consumer backpressure
    begin
      int n;
      n = 0;
      got.delete();
      for (int c = 0; c < 600 && got.size() < 20; c++) begin
        res_ready   = 1'($urandom_range(0, 1));
        mult_result = $urandom;
        if (n < 20 && input_RDY && $urandom_range(0, 3) != 0) begin
          mult_signal = 1'b1;
          tag_in      = TAG_W'(n + 5);
          n++;
        end else begin
          mult_signal = 1'b0;
        end
        if (res_valid && res_ready) got.push_back(res_tag);
        tick();
      end
      mult_signal = 1'b0;
      res_ready   = 1'b0;
      chk("t4_issued", n, 20);
      chk("t4_returned", got.size(), 20);
      for (int j = 0; j < got.size(); j++) chk("t4_tag_order", got[j], j + 5);
      chk("t4_exception", exception, 0);
    end

    // reset with two queued and two in flight
    for (int i = 0; i < 4; i++) begin
      tag_in      = TAG_W'(20 + i);
      mult_signal = 1'b1;
      mult_result = $urandom;
      tick();
    end
    mult_signal = 1'b0;
    repeat (2) tick();
    chk("t5_valid_before", res_valid, 1);
    chk("t5_rdy_before", input_RDY, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_res_valid", res_valid, 0);
    chk("t5_input_RDY", input_RDY, 1);
    chk("t5_exception", exception, 0);
    tick();
    tick();
    reset_n   = 1'b1;
    res_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      mult_result = $urandom;
      tick();
      chk("t5_no_stale", res_valid, 0);
    end
    res_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_result_queue.md
MULT_RESULT_QUEUE -- requirements
Module: mult_result_queue

Interface
REQ-001 SHALL have parameter MULT_LATENCY, default 4: edges from operand acceptance to a valid multiplier data_result.
REQ-002 SHALL have parameter DEPTH, default 4: result FIFO entries; power of two, 2..16.
REQ-003 SHALL have parameter TAG_W, default 5: width of the destination-register tag.
REQ-004 Ports (clock and reset first): clock  in  1  single clock, rising edge.
REQ-005 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 mult_signal  in  1  issue request; operands go to the multiplier in the same cycle.
REQ-007 tag_in  in  TAG_W  tag travelling with the issued operation.
REQ-008 mult_result  in  32  multiplier data_result output.
REQ-009 input_RDY  out  1  issue permitted this cycle.
REQ-010 res_valid  out  1  res_data/res_tag hold a valid product.
REQ-011 res_ready  in  1  consumer accepts at this edge when res_valid=1.
REQ-012 res_data  out  32  product;  res_tag  out  TAG_W  matching tag.
REQ-013 exception  out  1  sticky: an issue was dropped.

Function
REQ-014 Acceptance: SHALL accept an issue at an edge where mult_signal=1 and input_RDY=1.
REQ-015 Tracking: SHALL keep a MULT_LATENCY-stage valid+tag shift register.
- Stage 0 loads the acceptance bit and tag_in.
- All stages shift every edge; no stall exists.
REQ-016 Push: at an edge where the last stage is valid, SHALL push {mult_result, tag} into the FIFO. Acceptance at edge e pushes at edge e+MULT_LATENCY.
REQ-017 Credit: input_RDY SHALL equal (FIFO occupancy + valid in-flight stages) < DEPTH.
- Computed from registered state only; no combinational path from res_ready or mult_signal.
REQ-018 Pop: at an edge where res_valid=1 and res_ready=1, SHALL pop. A pop frees credit from the next cycle.
REQ-019 Simultaneous push and pop: both SHALL take effect at the same edge; occupancy is unchanged.
REQ-020 Overflow: the FIFO SHALL never overflow, because credit guarantees it. A push into a full FIFO is an assertion failure.
REQ-021 Ordering: results SHALL leave in issue order; pointers wrap modulo DEPTH.
REQ-022 Drop: mult_signal=1 with input_RDY=0 SHALL drop the request and set exception=1 at that edge. exception stays 1 until reset.
REQ-023 Output when idle: res_data and res_tag SHALL hold the FIFO head whenever res_valid=1. Their value is don't-care when res_valid=0.

Reset
REQ-024 While reset_n=0, SHALL clear all stage valids, FIFO pointers, occupancy and exception, asynchronously. In-flight operations are discarded.
REQ-025 Reset values: res_valid=0, exception=0, input_RDY=1, res_data=0, res_tag=0.
REQ-026 Deassertion SHALL be synchronised by the instantiating design. The first acceptance is legal at the first edge after release.

Configuration
REQ-027 Macro MULT_RESQ_BYPASS_EN SHALL select the bypass behaviour.
REQ-028 Defined: when the FIFO is empty and the last stage is valid, res_valid SHALL be 1 combinationally, with res_data=mult_result and res_tag=stage tag.
- If res_ready=1 at that edge, nothing is written to the FIFO.
- Latency from acceptance to res_valid = MULT_LATENCY-1 edges, i.e. visible in the cycle before the push edge.
REQ-029 Undefined: res_valid SHALL come only from the FIFO. Latency from acceptance to res_valid = MULT_LATENCY edges, and res_valid is registered.

Structure
REQ-030 Package mult_pkg SHALL hold MULT_LATENCY_DEF=4, MULT_DATA_W=32 and the tag-width default, shared with the multiplier wrapper.
REQ-031 Sub-module mult_resq_fifo SHALL contain:
- storage and pointers;
- occupancy counter (width clog2(DEPTH)+1);
- push/pop/full/empty.
Tracking, credit and bypass logic SHALL stay in the top level.

Verification
REQ-032 Single op: issue tag=3 with mult_result=0x0000_0F00 driven at the push edge, res_ready=1.
- Macro off: res_valid 4 edges later, res_data=0x0000_0F00, res_tag=3, single-cycle.
- Macro on: res_valid 3 edges later.
REQ-033 Back-to-back: issue every cycle with res_ready=0.
- input_RDY drops after 4 acceptances.
- A 5th mult_signal sets exception=1.
- Tags later pop in order 0,1,2,3.
REQ-034 Full plus simultaneous: FIFO at 3 entries, one in flight, pop and push at the same edge. Occupancy stays 3, input_RDY=0 → 1 the cycle after the pop.
REQ-035 Wrap: 20 ops with random res_ready. All 20 tags are returned in order, none lost, exception=0.
REQ-036 Reset mid-operation: reset_n=0 with 2 in flight and 2 queued.
- Immediately: res_valid=0, input_RDY=1, exception=0.
- No stale result appears after release.
